// File: rtl/uart_rx_cfg.sv
// Purpose : configurable UART receiver (5..9 data bits, none/odd/even parity, 1/2 stop bits)
//           that places each frame in a one-entry holding register.
// Latency : o_RX_Valid rises one cycle after the last stop-bit decision.
// Backpr. : the frame is held until o_RX_Valid & i_RX_Ready. A frame completing while the
//           register is full is dropped and o_Overrun is set (sticky until next accept).
//
// Ports   : i_Clock / i_Rst (sync, active-high), i_RX_Serial (idle-high line, pre-synchronised),
//           i_RX_Ready / o_RX_Valid handshake, o_RX_Data (LSB first on line),
//           o_Parity_Err, o_Frame_Err, o_Overrun (sticky), o_Busy (not ARM/IDLE).
// Option  : define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions (samples at M-1, M, M+1,
//           decided at M+1). Undefined: single sample at M.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst,
    input  logic                 i_RX_Serial,
    input  logic                 i_RX_Ready,
    output logic                 o_RX_Valid,
    output logic [DATA_BITS-1:0] o_RX_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int MID = (CLKS_PER_BIT - 1) / 2;

    localparam logic [2:0] ST_ARM   = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_PAR   = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    logic [2:0]           state;
    logic [CW-1:0]        clk_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_dat;
    logic                 par_err;
    logic                 frm_err;
    logic                 bit_val;
    logic                 tick;
    logic                 frame_done;
    logic                 par_xor;

`ifdef UART_RX_MAJORITY_EN
    // Decision moves to M+1 so the line value at M+1 is the third vote.
    localparam int DEC = MID + 1;
    logic [1:0] hist;   // hist[0] = line one cycle ago, hist[1] = two cycles ago

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], i_RX_Serial};
        end
    end

    assign bit_val = (hist[1] & hist[0]) | (hist[1] & i_RX_Serial) | (hist[0] & i_RX_Serial);
`else
    localparam int DEC = MID;
    assign bit_val = i_RX_Serial;
`endif

    // START waits only to the first decision point; afterwards every decision
    // is a full bit period after the previous one, which keeps it mid-bit.
    always_comb begin
        tick       = (state == ST_START) ? (clk_cnt == CW'(DEC))
                                         : (clk_cnt == CW'(CLKS_PER_BIT - 1));
        frame_done = (state == ST_STOP) && tick && (bit_idx == 4'(STOP_BITS - 1));
        par_xor    = ^{shift_dat, bit_val};
    end

    assign o_Busy = (state != ST_ARM) && (state != ST_IDLE);

    // Frame FSM
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            state     <= ST_ARM;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_dat <= '0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            case (state)
                ST_ARM: begin
                    clk_cnt <= '0;
                    if (i_RX_Serial) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!i_RX_Serial) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        clk_cnt <= '0;
                        if (!bit_val) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                            par_err <= 1'b0;
                            frm_err <= 1'b0;
                        end else begin
                            state <= ST_IDLE;   // glitch: nothing delivered
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        clk_cnt   <= '0;
                        shift_dat <= {bit_val, shift_dat[DATA_BITS-1:1]};
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? ST_PAR : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                ST_PAR: begin
                    if (tick) begin
                        clk_cnt <= '0;
                        par_err <= (PARITY == 1) ? ~par_xor : par_xor;
                        state   <= ST_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        clk_cnt <= '0;
                        if (!bit_val) begin
                            frm_err <= 1'b1;
                        end
                        // Rearm at the last stop decision, half a bit early,
                        // so back-to-back frames need no idle gap.
                        if (frame_done) begin
                            state   <= ST_IDLE;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= ST_ARM;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

    // Holding register and overrun flag
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            o_RX_Valid   <= 1'b0;
            o_RX_Data    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            if (frame_done && (!o_RX_Valid || i_RX_Ready)) begin
                o_RX_Valid   <= 1'b1;
                o_RX_Data    <= shift_dat;
                o_Parity_Err <= par_err;
                o_Frame_Err  <= frm_err | ~bit_val;   // include the stop bit decided this cycle
            end else if (o_RX_Valid && i_RX_Ready) begin
                o_RX_Valid <= 1'b0;
            end

            if (frame_done && o_RX_Valid && !i_RX_Ready) begin
                o_Overrun <= 1'b1;
            end else if (o_RX_Valid && i_RX_Ready) begin
                o_Overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Purpose : scoreboard bench for uart_rx_cfg (8N1 and 7E2 instances, CLKS_PER_BIT=16).
// Latency : expected frames queued at send time, popped by monitors on each handshake.
// Backpr. : bench drives i_RX_Ready directly to exercise hold, overrun and same-cycle reload.
module tb_uart_rx_cfg;

    localparam int C  = 16;
    localparam int M  = (C - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // negedge offset (from start-bit drive) at which the last stop decision of a 10-bit frame has not yet happened
    localparam int LAST10 = 9 * C + M + 1 + MAJ;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic rdy_a = 1'b0, rdy_b = 1'b0;

    logic       a_vld, a_pe, a_fe, a_ovr, a_busy;
    logic [7:0] a_dat;
    logic       b_vld, b_pe, b_fe, b_ovr, b_busy;
    logic [6:0] b_dat;

    exp_t qa[$];
    exp_t qb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .i_Clock(clk), .i_Rst(rst), .i_RX_Serial(rx_a), .i_RX_Ready(rdy_a),
        .o_RX_Valid(a_vld), .o_RX_Data(a_dat), .o_Parity_Err(a_pe), .o_Frame_Err(a_fe),
        .o_Overrun(a_ovr), .o_Busy(a_busy)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .i_Clock(clk), .i_Rst(rst), .i_RX_Serial(rx_b), .i_RX_Ready(rdy_b),
        .o_RX_Valid(b_vld), .o_RX_Data(b_dat), .o_Parity_Err(b_pe), .o_Frame_Err(b_fe),
        .o_Overrun(b_ovr), .o_Busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one frame, one bit per C cycles, changing the line on negedges.
    // glitch inverts each data bit for the single cycle holding its count-M sample.
    task automatic send(input bit sel_b, input logic [8:0] d, input int nb, input bit has_par,
                        input bit pb, input int nst, input bit stop_lo, input bit glitch);
        logic [15:0] fr;
        int          n;
        logic        v;
        fr    = '0;
        fr[0] = 1'b0;
        for (int i = 0; i < nb; i++) fr[1+i] = d[i];
        n = 1 + nb;
        if (has_par) begin
            fr[n] = pb;
            n++;
        end
        for (int s = 0; s < nst; s++) begin
            fr[n] = ~stop_lo;
            n++;
        end
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < C; c++) begin
                v = fr[k] ^ (glitch && k >= 1 && k <= nb && c == M + 1);
                if (sel_b) rx_b = v;
                else       rx_a = v;
                @(negedge clk);
            end
        end
    endtask

    function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        return e;
    endfunction

    // Monitors: a handshake happens at the posedge following a cycle with valid & ready.
    always begin : mon_a
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst && a_vld && rdy_a) begin
            if (qa.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL a_unexpected: got data %0h, expected no frame", a_dat);
            end else begin
                e = qa.pop_front();
                chk("a_data", 32'(a_dat), 32'(e.d[7:0]));
                chk("a_parity_err", 32'(a_pe), 32'(e.pe));
                chk("a_frame_err", 32'(a_fe), 32'(e.fe));
            end
        end
    end

    always begin : mon_b
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst && b_vld && rdy_b) begin
            if (qb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL b_unexpected: got data %0h, expected no frame", b_dat);
            end else begin
                e = qb.pop_front();
                chk("b_data", 32'(b_dat), 32'(e.d[6:0]));
                chk("b_parity_err", 32'(b_pe), 32'(e.pe));
                chk("b_frame_err", 32'(b_fe), 32'(e.fe));
            end
        end
    end

    initial begin
        // ---- reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(a_vld), 0);
        chk("rst_data", 32'(a_dat), 0);
        chk("rst_overrun", 32'(a_ovr), 0);
        chk("rst_busy", 32'(a_busy), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // ---- 8N1 0xA5: exact valid timing, then hold until ready
        qa.push_back(mk(9'h0A5, 1'b0, 1'b0));
        fork
            send(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
            begin
                repeat (LAST10) @(negedge clk);
                chk("a5_valid_before_last_sample", 32'(a_vld), 0);
                @(negedge clk);
                chk("a5_valid_after_last_sample", 32'(a_vld), 1);
            end
        join
        repeat (20) @(negedge clk);
        chk("a5_valid_held", 32'(a_vld), 1);
        chk("a5_data_held", 32'(a_dat), 32'h A5);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        chk("a5_valid_cleared", 32'(a_vld), 0);

        // ---- framing error then a clean frame
        rdy_a = 1'b1;
        qa.push_back(mk(9'h03C, 1'b0, 1'b1));
        send(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        rx_a = 1'b1;
        repeat (2 * C) @(negedge clk);
        qa.push_back(mk(9'h081, 1'b0, 1'b0));
        send(1'b0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        repeat (C) @(negedge clk);

        // ---- overrun: 0x11 held, 0x22 dropped
        rdy_a = 1'b0;
        qa.push_back(mk(9'h011, 1'b0, 1'b0));
        send(1'b0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        send(1'b0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("ovr_valid", 32'(a_vld), 1);
        chk("ovr_data_kept", 32'(a_dat), 32'h11);
        chk("ovr_flag_set", 32'(a_ovr), 1);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        chk("ovr_valid_cleared", 32'(a_vld), 0);
        chk("ovr_flag_cleared", 32'(a_ovr), 0);

        // ---- accept in the same cycle a new frame completes: reload, no overrun
        qa.push_back(mk(9'h033, 1'b0, 1'b0));
        qa.push_back(mk(9'h044, 1'b0, 1'b0));
        send(1'b0, 9'h033, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        fork
            send(1'b0, 9'h044, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
            begin
                repeat (LAST10) @(negedge clk);
                rdy_a = 1'b1;
                @(negedge clk);
                rdy_a = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("reload_overrun", 32'(a_ovr), 0);
        chk("reload_valid", 32'(a_vld), 1);
        chk("reload_data", 32'(a_dat), 32'h44);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;

        // ---- 3-cycle glitch: nothing delivered
        rdy_a = 1'b1;
        rx_a  = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * C) @(negedge clk);
        chk("glitch_no_valid", 32'(a_vld), 0);
        chk("glitch_idle", 32'(a_busy), 0);

        // ---- reset during data bit 4 with line held low through release
        rdy_a = 1'b0;
        send(1'b0, 9'h077, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);   // held, then discarded by reset
        rx_a = 1'b0;
        repeat (5 * C + 8) @(negedge clk);
        chk("mid_frame_busy", 32'(a_busy), 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst2_valid", 32'(a_vld), 0);
        chk("rst2_data", 32'(a_dat), 0);
        chk("rst2_frame_err", 32'(a_fe), 0);
        chk("rst2_busy", 32'(a_busy), 0);
        rst = 1'b0;
        repeat (3 * C) @(negedge clk);
        chk("arm_hold_busy", 32'(a_busy), 0);
        chk("arm_hold_valid", 32'(a_vld), 0);
        rx_a = 1'b1;
        repeat (5) @(negedge clk);
        rdy_a = 1'b1;
        qa.push_back(mk(9'h05A, 1'b0, 1'b0));
        send(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        repeat (C) @(negedge clk);

        // ---- per-bit mid-sample glitch on 0xC3
`ifdef UART_RX_MAJORITY_EN
        qa.push_back(mk(9'h0C3, 1'b0, 1'b0));
`else
        qa.push_back(mk(9'h03C, 1'b0, 1'b0));
`endif
        send(1'b0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        repeat (C) @(negedge clk);

        // ---- 7E2: 0x55 has four ones, so parity bit 1 is an even-parity error
        rdy_b = 1'b1;
        qb.push_back(mk(9'h055, 1'b1, 1'b0));
        send(1'b1, 9'h055, 7, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        qb.push_back(mk(9'h055, 1'b0, 1'b0));
        send(1'b1, 9'h055, 7, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        // 0x2A has three ones: parity bit 1 is correct; both stops low flags framing
        rx_b = 1'b1;
        repeat (C) @(negedge clk);
        qb.push_back(mk(9'h02A, 1'b0, 1'b1));
        send(1'b1, 9'h02A, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0);
        rx_b = 1'b1;
        repeat (3 * C) @(negedge clk);

        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        chk("b_overrun_clear", 32'(b_ovr), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
